// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI-slave register bank:
// register addresses, frame width and the receive state encoding.
package spi_reg_pkg;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;
    localparam logic [6:0] ADDR_MAX       = 7'h04;

    localparam int FRAME_BITS = 16;

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for one asynchronous pin, followed by a
// registered previous value so rise/fall come out as one-cycle pulses.
module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI-slave write-only register bank: deserialises 16-bit frames from the
// synchronised pins and commits well-formed writes to five PWM control registers.
module spi_reg_bank #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = spi_reg_pkg::FRAME_BITS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic       frame_err
);
    import spi_reg_pkg::*;

    localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
    localparam logic [4:0] CNT_SAT  = 5'(FRAME_BITS + 1);

    logic sclk_sync, sclk_rise, sclk_fall_unused;
    logic ncs_sync, ncs_rise, ncs_fall;
    logic copi_sync, copi_rise_unused, copi_fall_unused;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .din(sclk),
        .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall_unused)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ncs (
        .clk(clk), .rst(rst), .din(ncs),
        .sync(ncs_sync), .rise(ncs_rise), .fall(ncs_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_copi (
        .clk(clk), .rst(rst), .din(copi),
        .sync(copi_sync), .rise(copi_rise_unused), .fall(copi_fall_unused)
    );

    state_t                  state_q, state_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [SYNC_STAGES-1:0]  warm_q;
    logic                    armed_q;
    logic                    commit, err;

    logic       frame_rw;
    logic [6:0] frame_addr;
    logic [7:0] frame_data;

    assign frame_rw   = shift_q[FRAME_BITS-1];
    assign frame_addr = shift_q[FRAME_BITS-2 -: 7];
    assign frame_data = shift_q[7:0];

    // The ncs synchroniser resets high, so a pin already low at reset release
    // yields a spurious fall; frames are only accepted once ncs is seen high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            warm_q  <= {warm_q[SYNC_STAGES-2:0], 1'b1};
            armed_q <= armed_q | (warm_q[SYNC_STAGES-1] & ncs_sync);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        commit  = 1'b0;
        err     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ncs_fall && armed_q) begin
                    state_d = RECV;
                    cnt_d   = '0;
                end
            end
            RECV: begin
                if (ncs_fall) begin
                    cnt_d = '0;
                end else if (ncs_rise) begin
                    state_d = IDLE;
                    if (cnt_q != CNT_FULL) begin
                        err = 1'b1;
                    end else if (frame_rw) begin
                        commit = (frame_addr <= ADDR_MAX);
                        err    = (frame_addr > ADDR_MAX);
                    end
                end else if (sclk_rise && sclk_sync) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], copi_sync};
                    cnt_d   = (cnt_q == CNT_SAT) ? CNT_SAT : cnt_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            shift_q         <= '0;
            wr_strobe       <= 1'b0;
            frame_err       <= 1'b0;
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            wr_strobe <= commit;
            frame_err <= err;
            if (commit) begin
                case (frame_addr)
                    ADDR_EN_OUT_LO: en_reg_out_7_0  <= frame_data;
                    ADDR_EN_OUT_HI: en_reg_out_15_8 <= frame_data;
                    ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= frame_data;
                    ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= frame_data;
                    ADDR_DUTY:      pwm_duty_cycle  <= frame_data;
                    default: ;
                endcase
            end
        end
    end

endmodule
